pe_column_sequencer: RTL and testbench

//  Sequences one weight-stationary column of ROWS power-of-two-weight PEs:
//  - shifts a column of weights through the PE weight chain, then pulses the PE weight-load enable;
//  - streams cfg_num_vec activation vectors, inserting zero-activation bubbles when starved;
//  - tracks each vector to the column output, flags valid partial sums, signals done.

---
 rtl/pe_ctrl_pkg.sv | 19 +
 rtl/pe_column_sequencer_if.sv | 32 +++
 rtl/valid_delay_line.sv | 29 ++
 rtl/pe_column_sequencer.sv | 116 +++++++++++
 tb/tb_pe_column_sequencer.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/pe_ctrl_pkg.sv
// Shared types and helpers for the PE column sequencer.
package pe_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_WAIT,
        W_SHIFT,
        W_LOAD,
        COMP,
        DRAIN,
        DONE
    } seq_state_e;

    // Activation pop to column psum: ROWS-deep skew in, ROWS-deep accumulate, one output stage.
    function automatic int unsigned pipe_lat(input int unsigned rows);
        return 2 * rows + 1;
    endfunction

endpackage

// File: rtl/pe_column_sequencer_if.sv
// Handshake/config bundle between the buffers, the PE column and the column sequencer.
interface pe_column_sequencer_if #(
    parameter int unsigned VEC_W = 12
);

    logic             start;
    logic [VEC_W-1:0] cfg_num_vec;
    logic             cfg_reuse_w;
    logic             w_avail;
    logic             w_pop;
    logic             pe_weight_load;
    logic             act_avail;
    logic             act_pop;
    logic             act_zero;
    logic             psum_valid;
    logic             busy;
    logic             done;
    logic [VEC_W-1:0] vec_cnt;

    // Sequencer side.
    modport master (
        input  start, cfg_num_vec, cfg_reuse_w, w_avail, act_avail,
        output w_pop, pe_weight_load, act_pop, act_zero, psum_valid, busy, done, vec_cnt
    );

    // Buffer / array side.
    modport slave (
        output start, cfg_num_vec, cfg_reuse_w, w_avail, act_avail,
        input  w_pop, pe_weight_load, act_pop, act_zero, psum_valid, busy, done, vec_cnt
    );

endinterface

// File: rtl/valid_delay_line.sv
// Generic registered valid pipe: o_out is i_in delayed by DEPTH cycles, o_empty when no bit is set.
module valid_delay_line #(
    parameter int unsigned DEPTH = 9
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_out,
    output logic o_empty
);

    logic [DEPTH-1:0] r_pipe;

    // Shift every cycle regardless of sequencer state; only reset clears in-flight valids.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= i_in;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_out   = r_pipe[DEPTH-1];
    assign o_empty = (r_pipe == '0);

endmodule

// File: rtl/pe_column_sequencer.sv
// Sequencer for one weight-stationary PE column: weight shift/load, activation streaming with
// zero bubbles, and per-vector tracking to the column output.
module pe_column_sequencer
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned PIPE_LAT = pipe_lat(ROWS),
    parameter int unsigned VEC_W    = 12
) (
    input logic                  i_clk,
    input logic                  i_rst,
    pe_column_sequencer_if.master bus
);

    localparam int unsigned CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    seq_state_e       r_state;
    logic [CNT_W-1:0] r_shift_cnt;
    logic [VEC_W-1:0] r_vec_cnt;
    logic [VEC_W-1:0] r_num_vec;

    logic             w_act_pop;
    logic             w_psum_valid;
    logic             w_dly_empty;
    logic [VEC_W-1:0] w_vec_cnt_nxt;

    assign w_act_pop     = (r_state == COMP) && bus.act_avail;
    assign w_vec_cnt_nxt = r_vec_cnt + VEC_W'(1);

    // Job FSM with weight shift counter and issued-vector counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_shift_cnt <= '0;
            r_vec_cnt   <= '0;
            r_num_vec   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_num_vec <= bus.cfg_num_vec;
                        r_vec_cnt <= '0;
                        if (!bus.cfg_reuse_w) begin
                            r_state <= W_WAIT;
                        end else if (bus.cfg_num_vec == '0) begin
                            // Nothing to stream with resident weights: COMP could never exit.
                            r_state <= DRAIN;
                        end else begin
                            r_state <= COMP;
                        end
                    end
                end
                W_WAIT: begin
                    // Burst only once the whole column of weights is guaranteed.
                    if (bus.w_avail) begin
                        r_shift_cnt <= '0;
                        r_state     <= W_SHIFT;
                    end
                end
                W_SHIFT: begin
                    if (r_shift_cnt == CNT_W'(ROWS - 1)) begin
                        r_state <= W_LOAD;
                    end else begin
                        r_shift_cnt <= r_shift_cnt + CNT_W'(1);
                    end
                end
                W_LOAD: begin
                    r_state <= (r_num_vec == '0) ? DRAIN : COMP;
                end
                COMP: begin
                    if (w_act_pop) begin
                        r_vec_cnt <= w_vec_cnt_nxt;
                        if (w_vec_cnt_nxt == r_num_vec) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_dly_empty) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    valid_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_valid_dly (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_in    (w_act_pop),
        .o_out   (w_psum_valid),
        .o_empty (w_dly_empty)
    );

    // Output decode from registered state; act_pop is the only path from an input.
    always_comb begin
        bus.w_pop          = (r_state == W_SHIFT);
        bus.pe_weight_load = (r_state == W_LOAD);
        bus.act_pop        = w_act_pop;
        // Any cycle without a real vector feeds a zero activation into the column.
        bus.act_zero       = !w_act_pop;
        bus.psum_valid     = w_psum_valid;
        bus.busy           = (r_state != IDLE);
        bus.done           = (r_state == DONE);
        bus.vec_cnt        = r_vec_cnt;
    end

endmodule

// File: tb/tb_pe_column_sequencer.sv
// Self-checking bench for pe_column_sequencer: per-cycle expected control outputs plus a
// scoreboard of psum arrival cycles pushed at each expected pop.
module tb_pe_column_sequencer;

    localparam int unsigned ROWS     = 4;
    localparam int unsigned PIPE_LAT = 2 * ROWS + 1;
    localparam int unsigned VEC_W    = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   prev_vec = 0;
    int   sb_q[$];

    pe_column_sequencer_if #(.VEC_W(VEC_W)) bus ();

    pe_column_sequencer #(
        .ROWS     (ROWS),
        .PIPE_LAT (PIPE_LAT),
        .VEC_W    (VEC_W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One job from start (k=0) through the IDLE cycle after DONE, checking every cycle.
    task automatic do_job(input int nv, input bit reuse, input bit alt, input int wd,
                          input bit spur);
        int ws, comp_start, done_cyc, pops, k;
        bit in_comp, avail, exp_pop, exp_ps;
        ws         = 2 + wd;
        comp_start = reuse ? 1 : ws + int'(ROWS) + 1;
        done_cyc   = (nv == 0) ? comp_start + 1 : 32'h3fff_ffff;
        pops       = 0;
        k          = 0;
        while (k <= done_cyc + 1 && k < 4000) begin
            @(posedge clk);
            #1;
            in_comp = (nv != 0) && (k >= comp_start) && (pops < nv);
            avail   = in_comp ? (!alt || ((k - comp_start) % 2 == 0)) : 1'b1;
            bus.start       = (k == 0) || (spur && ((!reuse && k == ws + 1) || k == done_cyc));
            bus.cfg_num_vec = (k == 0) ? VEC_W'(nv) : VEC_W'(nv + 9);
            bus.cfg_reuse_w = (k == 0) ? reuse : !reuse;
            bus.w_avail     = (k >= 1 + wd) && !(k > ws && k < ws + int'(ROWS));
            bus.act_avail   = avail;
            exp_pop = in_comp && avail;
            #3;
            exp_ps = (sb_q.size() > 0) && (sb_q[0] == cyc);
            if (exp_ps) void'(sb_q.pop_front());
            check_eq("w_pop", 32'(bus.w_pop), 32'(!reuse && k >= ws && k < ws + int'(ROWS)));
            check_eq("weight_load", 32'(bus.pe_weight_load), 32'(!reuse && k == ws + int'(ROWS)));
            check_eq("act_pop", 32'(bus.act_pop), 32'(exp_pop));
            check_eq("act_zero", 32'(bus.act_zero), 32'(!exp_pop));
            check_eq("busy", 32'(bus.busy), 32'(k >= 1 && k <= done_cyc));
            check_eq("done", 32'(bus.done), 32'(k == done_cyc));
            check_eq("vec_cnt", 32'(bus.vec_cnt), (k == 0) ? prev_vec : pops);
            check_eq("psum_valid", 32'(bus.psum_valid), 32'(exp_ps));
            if (exp_pop) begin
                sb_q.push_back(cyc + int'(PIPE_LAT));
                pops++;
                if (pops == nv) done_cyc = k + int'(PIPE_LAT) + 2;
            end
            k++;
        end
        if (k >= 4000) check_eq("job_timeout", k, done_cyc + 1);
        bus.start = 1'b0;
        prev_vec  = nv;
        check_eq("sb_empty", sb_q.size(), 0);
    endtask

    // Reset in COMP with three vectors in flight, then confirm nothing leaks out.
    task automatic mid_comp_reset();
        @(posedge clk);
        #1;
        bus.start       = 1'b1;
        bus.cfg_num_vec = VEC_W'(5);
        bus.cfg_reuse_w = 1'b1;
        bus.act_avail   = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            #3;
            check_eq("rst_pre_pop", 32'(bus.act_pop), 32'd1);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        prev_vec = 0;
        #3;
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_act_zero", 32'(bus.act_zero), 32'd1);
        check_eq("rst_act_pop", 32'(bus.act_pop), 32'd0);
        check_eq("rst_vec_cnt", 32'(bus.vec_cnt), 32'd0);
        for (int i = 0; i < int'(PIPE_LAT) + 3; i++) begin
            check_eq("rst_psum_valid", 32'(bus.psum_valid), 32'd0);
            check_eq("rst_done", 32'(bus.done), 32'd0);
            @(posedge clk);
            #4;
        end
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.cfg_num_vec = '0;
        bus.cfg_reuse_w = 1'b0;
        bus.w_avail     = 1'b0;
        bus.act_avail   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #3;
        check_eq("reset_w_pop", 32'(bus.w_pop), 32'd0);
        check_eq("reset_weight_load", 32'(bus.pe_weight_load), 32'd0);
        check_eq("reset_act_pop", 32'(bus.act_pop), 32'd0);
        check_eq("reset_act_zero", 32'(bus.act_zero), 32'd1);
        check_eq("reset_psum_valid", 32'(bus.psum_valid), 32'd0);
        check_eq("reset_busy", 32'(bus.busy), 32'd0);
        check_eq("reset_done", 32'(bus.done), 32'd0);
        check_eq("reset_vec_cnt", 32'(bus.vec_cnt), 32'd0);

        do_job(3, 1'b0, 1'b0, 0, 1'b0);   // baseline load + 3 vectors
        do_job(4, 1'b0, 1'b1, 0, 1'b0);   // starved every other COMP cycle
        do_job(2, 1'b1, 1'b0, 0, 1'b0);   // resident weights
        do_job(0, 1'b0, 1'b0, 0, 1'b0);   // weight load only
        do_job(2, 1'b0, 1'b0, 2, 1'b1);   // late w_avail, stray starts in W_SHIFT and DONE
        do_job(1, 1'b1, 1'b0, 0, 1'b0);   // single vector
        mid_comp_reset();
        do_job(3, 1'b1, 1'b1, 0, 1'b0);   // clean job after abort

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
